// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: 3-bit opcode, 5-bit result with carry/borrow/shift-out in bit 4, one-cycle latency.
// Define ALU_4BIT_FLAGS_EN to add the registered zero and signed-overflow flag outputs.
module alu_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] op,
    input  logic       in_valid,
    output logic [4:0] out,
    output logic       out_valid
`ifdef ALU_4BIT_FLAGS_EN
    ,
    output logic       zero,
    output logic       ovf
`endif
);

    logic [4:0] res_next;

    always_comb begin
        res_next = 5'd0;
        case (op)
            3'b000:  res_next = {1'b0, A} + {1'b0, B};
            // Modulo-32 subtraction leaves bit 4 set exactly when A < B.
            3'b001:  res_next = {1'b0, A} - {1'b0, B};
            3'b010:  res_next = {1'b0, A & B};
            3'b011:  res_next = {1'b0, A | B};
            3'b100:  res_next = {1'b0, A ^ B};
            3'b101:  res_next = {1'b0, ~A};
            3'b110:  res_next = {A, 1'b0};
            3'b111:  res_next = {2'b00, A[3:1]};
            default: res_next = 5'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= 5'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= res_next;
            end
        end
    end

`ifdef ALU_4BIT_FLAGS_EN
    logic ovf_next;

    // Signed overflow only has meaning for ADD and SUB; every other opcode reports 0.
    always_comb begin
        ovf_next = 1'b0;
        case (op)
            3'b000:  ovf_next = (A[3] == B[3]) && (res_next[3] != A[3]);
            3'b001:  ovf_next = (A[3] != B[3]) && (res_next[3] != A[3]);
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            zero <= (res_next[3:0] == 4'd0);
            ovf  <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: directed vectors push hand-computed expectations, a monitor pops and checks.
// Flag checks are compiled in only when ALU_4BIT_FLAGS_EN is defined.
module tb_alu_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] op;
    logic       in_valid;
    logic [4:0] out;
    logic       out_valid;
`ifdef ALU_4BIT_FLAGS_EN
    logic       zero;
    logic       ovf;
`endif

    typedef struct {
        logic [4:0] out;
        logic       valid;
        logic       zero;
        logic       ovf;
        string      name;
    } expect_t;

    expect_t scoreboard[$];
    int vectors_applied = 0;
    int miscompares     = 0;

    alu_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .op        (op),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
`ifdef ALU_4BIT_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expectation describes the state after the next rising edge.
    task automatic applyStimulus(input string name, input logic rst, input logic vld,
                                 input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                                 input logic [4:0] exp_out, input logic exp_valid,
                                 input logic exp_zero, input logic exp_ovf);
        expect_t e;
        @(negedge clk);
        rst_n    = rst;
        in_valid = vld;
        op       = o;
        A        = a;
        B        = b;
        e.out    = exp_out;
        e.valid  = exp_valid;
        e.zero   = exp_zero;
        e.ovf    = exp_ovf;
        e.name   = name;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input expect_t e);
        logic bad;
        vectors_applied++;
        bad = (out !== e.out) || (out_valid !== e.valid);
`ifdef ALU_4BIT_FLAGS_EN
        bad = bad || (zero !== e.zero) || (ovf !== e.ovf);
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%b valid=%b zero=%b ovf=%b, required out=%b valid=%b zero=%b ovf=%b",
                     e.name, out, out_valid, zero, ovf, e.out, e.valid, e.zero, e.ovf);
        end
`else
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%b valid=%b, required out=%b valid=%b",
                     e.name, out, out_valid, e.out, e.valid);
        end
`endif
    endtask

    // Monitor: one expectation is retired per clock, sampled just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() > 0) begin
                checkOutput(scoreboard.pop_front());
            end
        end
    end

    initial begin
        int budget;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 3'b000;
        A        = 4'd0;
        B        = 4'd0;

        //            name            rst  vld  op      A        B        out       vld  z    o
        applyStimulus("reset0",       0,   0,   3'b000, 4'h0,    4'h0,    5'b00000, 0,   0,   0);
        applyStimulus("reset1",       0,   1,   3'b000, 4'hF,    4'hF,    5'b00000, 0,   0,   0);
        applyStimulus("add_carry",    1,   1,   3'b000, 4'b1111, 4'b1111, 5'b11110, 1,   0,   0);
        applyStimulus("add_ovf",      1,   1,   3'b000, 4'b0111, 4'b0001, 5'b01000, 1,   0,   1);
        applyStimulus("sub",          1,   1,   3'b001, 4'b1111, 4'b1000, 5'b00111, 1,   0,   0);
        applyStimulus("sub_borrow",   1,   1,   3'b001, 4'b0000, 4'b0001, 5'b11111, 1,   0,   0);
        applyStimulus("and",          1,   1,   3'b010, 4'b1111, 4'b0011, 5'b00011, 1,   0,   0);
        applyStimulus("or",           1,   1,   3'b011, 4'b1111, 4'b1100, 5'b01111, 1,   0,   0);
        applyStimulus("xor",          1,   1,   3'b100, 4'b0101, 4'b1010, 5'b01111, 1,   0,   0);
        applyStimulus("not_zero",     1,   1,   3'b101, 4'b1111, 4'b0000, 5'b00000, 1,   1,   0);
        applyStimulus("shl",          1,   1,   3'b110, 4'b1111, 4'b0000, 5'b11110, 1,   0,   0);
        applyStimulus("shr",          1,   1,   3'b111, 4'b1111, 4'b0000, 5'b00111, 1,   0,   0);
        applyStimulus("gap_hold",     1,   0,   3'b000, 4'b0011, 4'b0011, 5'b00111, 0,   0,   0);
        applyStimulus("gap_hold2",    1,   0,   3'b110, 4'b1001, 4'b0110, 5'b00111, 0,   0,   0);
        applyStimulus("reset_mid",    0,   1,   3'b000, 4'b1111, 4'b1111, 5'b00000, 0,   0,   0);
        applyStimulus("post_reset",   1,   1,   3'b000, 4'b0011, 4'b0101, 5'b01000, 1,   0,   1);
        applyStimulus("sub_eq_zero",  1,   1,   3'b001, 4'b0101, 4'b0101, 5'b00000, 1,   1,   0);
        applyStimulus("sub_ovf",      1,   1,   3'b001, 4'b1000, 4'b0001, 5'b00111, 1,   0,   1);
        applyStimulus("hold_ovf",     1,   0,   3'b010, 4'b0000, 4'b0000, 5'b00111, 0,   0,   1);
        applyStimulus("add_wrap",     1,   1,   3'b000, 4'b1000, 4'b1000, 5'b10000, 1,   1,   1);
        applyStimulus("shl_msb0",     1,   1,   3'b110, 4'b0101, 4'b1111, 5'b01010, 1,   0,   0);
        applyStimulus("shr_lsb",      1,   1,   3'b111, 4'b0001, 4'b1111, 5'b00000, 1,   1,   0);

        @(negedge clk);
        in_valid = 1'b0;

        budget = 20;
        while (scoreboard.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (scoreboard.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, required 0", scoreboard.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
